// File: rtl/ttt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared types, win-line masks and board helper functions for
//               the tic-tac-toe move sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    typedef enum logic [2:0] {
        WAIT_X  = 3'd0,
        CHECK_X = 3'd1,
        O_SCAN  = 3'd2,
        CHECK_O = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        X_WIN = 2'b01,
        O_WIN = 2'b10,
        DRAW  = 2'b11
    } winner_t;

    // Squares are row-major, bit 0 = top-left.
    localparam logic [7:0][8:0] WIN_LINES = {
        9'h054,   // diagonal 2,4,6
        9'h111,   // diagonal 0,4,8
        9'h124,   // column 2,5,8
        9'h092,   // column 1,4,7
        9'h049,   // column 0,3,6
        9'h1C0,   // row 6,7,8
        9'h038,   // row 3,4,5
        9'h007    // row 0,1,2
    };

    localparam logic [8:0] BOARD_FULL = 9'h1FF;

    // True when exactly one bit of the square vector is set.
    function automatic logic is_onehot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    // One-hot mask of the lowest-numbered empty square (zero if board full).
    function automatic logic [8:0] lowest_empty(input logic [8:0] occ);
        return ~occ & (occ + 9'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_line_check.sv
`default_nettype none
// ============================================================================
// Module      : ttt_line_check
// Description : Combinational detector: flags a player board that fully
//               covers any of the eight tic-tac-toe lines.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [8:0] board,
    output logic       win
);

    // OR-reduce the per-line "all squares owned" tests.
    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ttt_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ttt_move_sequencer
// Description : Game controller. Owns the X/O boards, accepts human moves
//               over valid/ready, arbitrates the computer reply across
//               prioritised strategy candidates and tracks win/draw.
//               Optional macro TTT_TIMEOUT_EN adds a per-move human timeout
//               that forfeits the game to O.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_move_sequencer
    import ttt_pkg::*;
#(
    parameter int NUM_STRAT      = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      new_game,
    input  logic                      x_valid,
    input  logic [8:0]                x_move,
    output logic                      x_ready,
    output logic                      x_err,
    input  logic [NUM_STRAT-1:0][8:0] strat_move,
    output logic [8:0]                xin,
    output logic [8:0]                oin,
    output logic [8:0]                o_move,
    output logic                      o_move_valid,
    output logic                      game_over,
    output logic [1:0]                winner
);

    localparam int IDX_W = (NUM_STRAT > 1) ? $clog2(NUM_STRAT) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_STRAT - 1);

    state_t           state_q, state_d;
    winner_t          winner_q, winner_d;
    logic [8:0]       xin_q, xin_d;
    logic [8:0]       oin_q, oin_d;
    logic [8:0]       o_move_q, o_move_d;
    logic             o_move_valid_q, o_move_valid_d;
    logic             x_err_q, x_err_d;
    logic             game_over_q, game_over_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [8:0]       w_occ;
    logic [8:0]       w_cand;
    logic             w_x_win;
    logic             w_o_win;
    logic             w_x_legal;

`ifdef TTT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    ttt_line_check u_x_check (.board(xin_q), .win(w_x_win));
    ttt_line_check u_o_check (.board(oin_q), .win(w_o_win));

    assign w_occ     = xin_q | oin_q;
    assign w_cand    = strat_move[idx_q];
    assign w_x_legal = is_onehot(x_move) && ((x_move & w_occ) == 9'd0);

    // Next-state and datapath updates; new_game overrides every state.
    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        xin_d          = xin_q;
        oin_d          = oin_q;
        o_move_d       = o_move_q;
        o_move_valid_d = 1'b0;
        x_err_d        = 1'b0;
        game_over_d    = game_over_q;
        idx_d          = idx_q;
`ifdef TTT_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        if (new_game) begin
            state_d     = WAIT_X;
            winner_d    = NONE;
            xin_d       = 9'd0;
            oin_d       = 9'd0;
            o_move_d    = 9'd0;
            game_over_d = 1'b0;
            idx_d       = '0;
`ifdef TTT_TIMEOUT_EN
            cnt_d       = '0;
`endif
        end else begin
            case (state_q)
                WAIT_X: begin
                    if (x_valid && w_x_legal) begin
                        xin_d   = xin_q | x_move;
                        state_d = CHECK_X;
`ifdef TTT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        x_err_d = x_valid;
`ifdef TTT_TIMEOUT_EN
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            winner_d    = O_WIN;
                            game_over_d = 1'b1;
                            state_d     = DONE;
                            x_err_d     = 1'b0;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`endif
                    end
                end
                CHECK_X: begin
                    if (w_x_win) begin
                        winner_d    = X_WIN;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (w_occ == BOARD_FULL) begin
                        winner_d    = DRAW;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = O_SCAN;
                    end
                end
                O_SCAN: begin
                    // Board cannot be full here, so the fallback always finds a square.
                    if (is_onehot(w_cand) && ((w_cand & w_occ) == 9'd0)) begin
                        oin_d          = oin_q | w_cand;
                        o_move_d       = w_cand;
                        o_move_valid_d = 1'b1;
                        state_d        = CHECK_O;
                    end else if (idx_q == C_LAST_IDX) begin
                        oin_d          = oin_q | lowest_empty(w_occ);
                        o_move_d       = lowest_empty(w_occ);
                        o_move_valid_d = 1'b1;
                        state_d        = CHECK_O;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                CHECK_O: begin
                    if (w_o_win) begin
                        winner_d    = O_WIN;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else if (w_occ == BOARD_FULL) begin
                        winner_d    = DRAW;
                        game_over_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT_X;
                    end
                end
                DONE: begin
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_X;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= WAIT_X;
            winner_q       <= NONE;
            xin_q          <= 9'd0;
            oin_q          <= 9'd0;
            o_move_q       <= 9'd0;
            o_move_valid_q <= 1'b0;
            x_err_q        <= 1'b0;
            game_over_q    <= 1'b0;
            idx_q          <= '0;
`ifdef TTT_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            winner_q       <= winner_d;
            xin_q          <= xin_d;
            oin_q          <= oin_d;
            o_move_q       <= o_move_d;
            o_move_valid_q <= o_move_valid_d;
            x_err_q        <= x_err_d;
            game_over_q    <= game_over_d;
            idx_q          <= idx_d;
`ifdef TTT_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign x_ready      = (state_q == WAIT_X);
    assign x_err        = x_err_q;
    assign xin          = xin_q;
    assign oin          = oin_q;
    assign o_move       = o_move_q;
    assign o_move_valid = o_move_valid_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_move_sequencer
// Description : Directed self-checking bench for ttt_move_sequencer with an
//               expected-O-reply scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_move_sequencer;

    localparam int NUM_STRAT = 4;

    logic                      clk;
    logic                      rst_n;
    logic                      new_game;
    logic                      x_valid;
    logic [8:0]                x_move;
    logic                      x_ready;
    logic                      x_err;
    logic [NUM_STRAT-1:0][8:0] strat_move;
    logic [8:0]                xin;
    logic [8:0]                oin;
    logic [8:0]                o_move;
    logic                      o_move_valid;
    logic                      game_over;
    logic [1:0]                winner;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [8:0] mv;
        int         lat;
    } exp_t;
    exp_t sb[$];

    ttt_move_sequencer #(.NUM_STRAT(NUM_STRAT), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game),
        .x_valid(x_valid), .x_move(x_move), .x_ready(x_ready), .x_err(x_err),
        .strat_move(strat_move), .xin(xin), .oin(oin), .o_move(o_move),
        .o_move_valid(o_move_valid), .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one human move for a single cycle once the controller is ready.
    task automatic play_x(input logic [8:0] mv);
        int n;
        n = 0;
        while (x_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("x_ready_wait", x_ready, 1);
        x_valid = 1'b1;
        x_move  = mv;
        step();
        x_valid = 1'b0;
        x_move  = 9'd0;
    endtask

    // Wait for the O commit, measuring cycles from the accepted X edge.
    task automatic wait_o(input string tag);
        int   lat;
        exp_t e;
        lat = 0;
        while (o_move_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_valid"}, o_move_valid, 1);
            check({tag, "_o_move"}, o_move, e.mv);
            check({tag, "_latency"}, lat, e.lat);
            step();
            check({tag, "_pulse_len"}, o_move_valid, 0);
        end
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n      = 1'b0;
        new_game   = 1'b0;
        x_valid    = 1'b0;
        x_move     = 9'd0;
        strat_move = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset / idle state
        check("rst_xin", xin, 0);
        check("rst_oin", oin, 0);
        check("rst_x_ready", x_ready, 1);
        check("rst_winner", winner, 0);
        check("rst_game_over", game_over, 0);
        check("rst_o_move_valid", o_move_valid, 0);
        check("rst_x_err", x_err, 0);

        // Illegal two-hot move
        play_x(9'h003);
        check("illegal_x_err", x_err, 1);
        check("illegal_xin", xin, 0);
        check("illegal_x_ready", x_ready, 1);
        step();
        check("illegal_x_err_pulse", x_err, 0);

        // Priority: strat0 empty, strat1 occupied by X, strat2 -> square 3
        strat_move[0] = 9'h000;
        strat_move[1] = 9'h010;
        strat_move[2] = 9'h008;
        strat_move[3] = 9'h100;
        e.mv = 9'h008; e.lat = 4; sb.push_back(e);
        play_x(9'h010);
        check("legal_xin", xin, 9'h010);
        check("legal_x_ready_low", x_ready, 0);
        wait_o("prio");
        check("prio_oin", oin, 9'h008);

        // Re-offer an occupied square once WAIT_X returns
        play_x(9'h010);
        check("dup_x_err", x_err, 1);
        check("dup_xin", xin, 9'h010);
        check("dup_oin", oin, 9'h008);

        // Fallback: no suggestions, O takes the lowest empty square
        pulse_new_game();
        check("ng_xin", xin, 0);
        check("ng_oin", oin, 0);
        check("ng_x_ready", x_ready, 1);
        strat_move = '0;
        e.mv = 9'h002; e.lat = 1 + NUM_STRAT; sb.push_back(e);
        play_x(9'h001);
        wait_o("fallback");
        check("fallback_oin", oin, 9'h002);

        // X row win; O answers via strategy 0 on squares 8 then 7
        pulse_new_game();
        strat_move[0] = 9'h100;
        e.mv = 9'h100; e.lat = 2; sb.push_back(e);
        play_x(9'h001);
        wait_o("row_o1");
        strat_move[0] = 9'h080;
        e.mv = 9'h080; e.lat = 2; sb.push_back(e);
        play_x(9'h002);
        wait_o("row_o2");
        strat_move[0] = 9'h040;
        play_x(9'h004);
        step();
        check("row_winner", winner, 2'b01);
        check("row_game_over", game_over, 1);
        check("row_x_ready", x_ready, 0);
        check("row_xin", xin, 9'h007);
        check("row_oin", oin, 9'h180);
        x_valid = 1'b1;
        x_move  = 9'h008;
        repeat (3) step();
        x_valid = 1'b0;
        x_move  = 9'd0;
        check("done_hold_xin", xin, 9'h007);
        check("done_hold_winner", winner, 2'b01);
        check("done_no_o", o_move_valid, 0);

        // Draw: X 0,2,3,7,8 / O 4,1,6,5
        pulse_new_game();
        strat_move[0] = 9'h010; e.mv = 9'h010; e.lat = 2; sb.push_back(e);
        play_x(9'h001);
        wait_o("draw_o1");
        strat_move[0] = 9'h002; e.mv = 9'h002; e.lat = 2; sb.push_back(e);
        play_x(9'h004);
        wait_o("draw_o2");
        strat_move[0] = 9'h040; e.mv = 9'h040; e.lat = 2; sb.push_back(e);
        play_x(9'h008);
        wait_o("draw_o3");
        strat_move[0] = 9'h020; e.mv = 9'h020; e.lat = 2; sb.push_back(e);
        play_x(9'h080);
        wait_o("draw_o4");
        play_x(9'h100);
        step();
        check("draw_winner", winner, 2'b11);
        check("draw_game_over", game_over, 1);
        check("draw_xin", xin, 9'h18D);
        check("draw_oin", oin, 9'h072);

        // Restart after draw
        pulse_new_game();
        check("restart_xin", xin, 0);
        check("restart_oin", oin, 0);
        check("restart_winner", winner, 0);
        check("restart_game_over", game_over, 0);
        check("restart_x_ready", x_ready, 1);

        // Asynchronous reset in the middle of O_SCAN
        strat_move = '0;
        play_x(9'h001);
        step();
        step();
        check("mid_scan_busy", x_ready, 0);
        rst_n = 1'b0;
        #1;
        check("arst_xin", xin, 0);
        check("arst_oin", oin, 0);
        check("arst_o_move", o_move, 0);
        check("arst_o_move_valid", o_move_valid, 0);
        check("arst_winner", winner, 0);
        check("arst_game_over", game_over, 0);
        check("arst_x_ready", x_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ttt_move_sequencer.md
Name: ttt_move_sequencer

Overview:
- Clocked game controller for the tic-tac-toe datapath.
- Owns the X (human) and O (computer) board registers and accepts human moves over a valid/ready handshake.
- Arbitrates the computer's reply across NUM_STRAT combinational strategy units (win, block, adjacent-edge, etc.). These units read its board outputs and each returns a 9-bit candidate move.
- Detects win/draw and holds the game-over state until a new game is requested.

Parameters:
- NUM_STRAT, 4, number of strategy candidate inputs; index 0 has the highest priority.
- TIMEOUT_CYCLES, 1000, cycles the human is allowed per move (used only with TTT_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- new_game  input  1  single-cycle request to clear the board and restart
- x_valid  input  1  human move offered
- x_move  input  9  human move, one-hot, bit i = square i (row-major, 0 = top-left)
- x_ready  output  1  controller will accept x_move this cycle
- x_err  output  1  one-cycle pulse: offered move illegal, rejected
- strat_move  input  NUM_STRAT×9  candidate moves from strategy units (all-zero = no suggestion)
- xin  output  9  X board register
- oin  output  9  O board register
- o_move  output  9  one-hot square O just took; valid when o_move_valid
- o_move_valid  output  1  one-cycle pulse on O commit
- game_over  output  1  game finished
- winner  output  2  00 none, 01 X, 10 O, 11 draw

Behaviour:
- Reset (async, rst_n low):
  - xin = oin = 0, o_move = 0.
  - o_move_valid = x_err = game_over = 0, winner = 00.
  - State = WAIT_X, x_ready = 1.
- States: WAIT_X, CHECK_X, O_SCAN, CHECK_O, DONE.
- WAIT_X:
  - x_ready = 1.
  - On x_valid: the move is legal iff x_move is one-hot and (x_move & (xin|oin)) == 0.
    - Legal: xin |= x_move next edge, go to CHECK_X.
    - Illegal: x_err pulses for 1 cycle, state is unchanged, board is unchanged.
  - x_ready = 0 in all other states; x_valid is ignored there.
- CHECK_X (1 cycle):
  - X owns any of the 8 win lines → winner = 01, go to DONE.
  - Else board full (xin|oin == 9'h1FF) → winner = 11, go to DONE.
  - Else go to O_SCAN with idx = 0.
- O_SCAN (one strategy examined per cycle):
  - If strat_move[idx] is one-hot and that square is empty: commit it, i.e. oin |= cand, o_move = cand, o_move_valid pulses. Go to CHECK_O.
  - Else idx++.
  - If idx == NUM_STRAT-1 and no candidate qualifies: commit the lowest-indexed empty square in that same cycle.
  - Latency: O commit occurs k+1 cycles after entering O_SCAN, where k is the index of the accepted strategy; the worst case is NUM_STRAT cycles.
  - strat_move is sampled combinationally in the cycle it is examined. Strategy units see the updated xin from CHECK_X onward.
- CHECK_O (1 cycle): O wins → winner = 10, DONE. Else board full → 11, DONE. Else WAIT_X.
- DONE: game_over = 1; winner, xin and oin are held.
- new_game:
  - Has priority in every state: next edge clears xin, oin, o_move, winner and game_over, and goes to WAIT_X.
  - If x_valid is high in the same cycle, the move is dropped.
- Win lines: rows {0,1,2} {3,4,5} {6,7,8}; columns {0,3,6} {1,4,7} {2,5,8}; diagonals {0,4,8} {2,4,6}.
- An X win on the 9th square reports 01, not 11 (win is checked before full).

Optional Feature:
- Macro: TTT_TIMEOUT_EN.
- Defined: a counter in WAIT_X counts cycles without an accepted move. On reaching TIMEOUT_CYCLES the human forfeits: winner = 10, game goes to DONE. The counter clears on any legal move, on new_game, and on reset.
- Undefined: no counter is built; WAIT_X waits indefinitely.

Decomposition:
- Package ttt_pkg:
  - state_t enum.
  - winner_t enum (NONE/X_WIN/O_WIN/DRAW).
  - localparam WIN_LINES[8] as 9-bit masks.
  - BOARD_FULL = 9'h1FF.
- Sub-module ttt_line_check (combinational): input 9-bit player board, output win flag. Instantiated twice, once for xin and once for oin.
- One-hot check and lowest-empty priority encoder are functions in ttt_pkg.

Test Plan:
- Reset then idle: xin = oin = 0, x_ready = 1, winner = 00, game_over = 0.
- Illegal move:
  - x_move = 9'b000_000_011 → x_err pulse, xin unchanged.
  - Then legal 9'b000_010_000 → xin = 9'h010.
  - Then x_move = 9'h010 again when WAIT_X returns → x_err pulse.
- Arbitration priority:
  - strat_move[0] = 0, strat_move[1] = 9'h010 (occupied), strat_move[2] = 9'b000_001_000, after X plays 9'h010.
  - Required: oin = 9'h008, o_move_valid pulses exactly 3 cycles after O_SCAN entry.
- Fallback: all strat_move = 0 after X plays square 0 → O takes square 1 (oin = 9'h002) after NUM_STRAT cycles.
- X row win: X plays 0, 1, 2 while strategy units point at 8, 7, 6 → winner = 01, game_over = 1, x_ready stays 0.
- Draw and restart:
  - Drive a 9-square sequence with no line → winner = 11.
  - Then new_game → board 0 and WAIT_X.
  - Assert rst_n low mid O_SCAN → all outputs at reset values immediately.
- TTT_TIMEOUT_EN with TIMEOUT_CYCLES = 10: no x_valid for 10 cycles → winner = 10, game_over = 1.
